// File: rtl/wb_arbiter.sv
// Writeback arbiter: single-cycle ALU results win the register-file write
// port; long-latency results wait in a small FIFO. Also tracks pending dests.
// Ports: clk, rst (async active-low); alu_v/alu_rd/alu_data (ALU result);
// lsu_v/lsu_rd/lsu_data/lsu_rdy (long-latency result, handshake);
// issue_v/issue_rd (long-latency issue); wb_we/wb_addr/wb_data (regfile
// write, registered); busy (pending mask); stall; waw_err (sticky).
module wb_arbiter #(
    parameter int FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        alu_v,
    input  logic [4:0]  alu_rd,
    input  logic [31:0] alu_data,
    input  logic        lsu_v,
    input  logic [4:0]  lsu_rd,
    input  logic [31:0] lsu_data,
    output logic        lsu_rdy,
    input  logic        issue_v,
    input  logic [4:0]  issue_rd,
    output logic        wb_we,
    output logic [4:0]  wb_addr,
    output logic [31:0] wb_data,
    output logic [31:0] busy,
    output logic        stall,
    output logic        waw_err
);
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
    localparam logic [PW-1:0] LAST_P  = PW'(FIFO_DEPTH - 1);

    logic [4:0]    fifo_rd   [FIFO_DEPTH];
    logic [31:0]   fifo_data [FIFO_DEPTH];
    logic [CW-1:0] count;
    logic [PW-1:0] rptr;
    logic [PW-1:0] wptr;
    logic          push;
    logic          pop;
    logic [4:0]    head_rd;
    logic [31:0]   head_data;
    logic [31:0]   busy_nxt;

    // Both flags look only at the registered count, so a push and a pop on
    // the same edge never let a full buffer take a new entry.
    assign lsu_rdy   = (count < DEPTH_C);
    assign stall     = (count >= (DEPTH_C - CW'(1)));
    assign push      = lsu_v & lsu_rdy;
    assign pop       = ~alu_v & (count != '0);
    assign head_rd   = fifo_rd[rptr];
    assign head_data = fifo_data[rptr];

    // Clear for the entry being written back, then set for a new issue, so
    // a same-cycle issue to the same register keeps the bit set.
    always_comb begin
        busy_nxt = busy;
        if (pop) begin
            busy_nxt[head_rd] = 1'b0;
        end
        if (issue_v) begin
            busy_nxt[issue_rd] = 1'b1;
        end
        busy_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_rd[wptr]   <= lsu_rd;
            fifo_data[wptr] <= lsu_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count   <= '0;
            rptr    <= '0;
            wptr    <= '0;
            busy    <= '0;
            waw_err <= 1'b0;
            wb_we   <= 1'b0;
            wb_addr <= '0;
            wb_data <= '0;
        end else begin
            if (push) begin
                wptr <= (wptr == LAST_P) ? '0 : wptr + PW'(1);
            end
            if (pop) begin
                rptr <= (rptr == LAST_P) ? '0 : rptr + PW'(1);
            end
            if (push && !pop) begin
                count <= count + CW'(1);
            end else if (pop && !push) begin
                count <= count - CW'(1);
            end
            busy <= busy_nxt;
            if (alu_v && busy[alu_rd]) begin
                waw_err <= 1'b1;
            end
            if (alu_v) begin
                wb_we   <= (alu_rd != 5'd0);
                wb_addr <= alu_rd;
                wb_data <= alu_data;
            end else if (pop) begin
                wb_we   <= (head_rd != 5'd0);
                wb_addr <= head_rd;
                wb_data <= head_data;
            end else begin
                wb_we <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_wb_arbiter.sv
// Testbench for wb_arbiter: directed scenarios plus random traffic checked
// against a queue-based model of the writeback rules.
module tb_wb_arbiter;
    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        alu_v = 1'b0;
    logic [4:0]  alu_rd = '0;
    logic [31:0] alu_data = '0;
    logic        lsu_v = 1'b0;
    logic [4:0]  lsu_rd = '0;
    logic [31:0] lsu_data = '0;
    logic        lsu_rdy;
    logic        issue_v = 1'b0;
    logic [4:0]  issue_rd = '0;
    logic        wb_we;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic [31:0] busy;
    logic        stall;
    logic        waw_err;

    wb_arbiter #(.FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .alu_v(alu_v), .alu_rd(alu_rd), .alu_data(alu_data),
        .lsu_v(lsu_v), .lsu_rd(lsu_rd), .lsu_data(lsu_data),
        .lsu_rdy(lsu_rdy),
        .issue_v(issue_v), .issue_rd(issue_rd),
        .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data),
        .busy(busy), .stall(stall), .waw_err(waw_err)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    logic [36:0] q[$];
    logic [31:0] m_busy = '0;
    logic        m_waw = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Drive one cycle of inputs, advance the model, check all outputs.
    task automatic cyc(input logic av, input logic [4:0] ard,
                       input logic [31:0] ad, input logic lv,
                       input logic [4:0] lrd, input logic [31:0] ld,
                       input logic iv, input logic [4:0] ird);
        logic        do_push;
        logic        e_we;
        logic [4:0]  e_addr;
        logic [31:0] e_data;
        logic [36:0] ent;
        alu_v = av; alu_rd = ard; alu_data = ad;
        lsu_v = lv; lsu_rd = lrd; lsu_data = ld;
        issue_v = iv; issue_rd = ird;
        do_push = lv && (q.size() < DEPTH);
        e_we = 1'b0; e_addr = '0; e_data = '0;
        if (av) begin
            e_we = (ard != 0); e_addr = ard; e_data = ad;
            if (m_busy[ard]) m_waw = 1'b1;
        end else if (q.size() > 0) begin
            ent = q.pop_front();
            e_addr = ent[36:32]; e_data = ent[31:0];
            e_we = (e_addr != 0);
            m_busy[e_addr] = 1'b0;
        end
        if (do_push) q.push_back({lrd, ld});
        if (iv && ird != 0) m_busy[ird] = 1'b1;
        @(posedge clk);
        #1;
        chk("wb_we", 32'(wb_we), 32'(e_we));
        if (e_we) begin
            chk("wb_addr", 32'(wb_addr), 32'(e_addr));
            chk("wb_data", wb_data, e_data);
        end
        chk("lsu_rdy", 32'(lsu_rdy), 32'(q.size() < DEPTH));
        chk("stall", 32'(stall), 32'(q.size() >= DEPTH - 1));
        chk("busy", busy, m_busy);
        chk("waw_err", 32'(waw_err), 32'(m_waw));
    endtask

    task automatic idle();
        cyc(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic rand_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            logic av;
            av = ($urandom_range(0, 3) != 0) && !(stall && $urandom_range(0, 3) != 0);
            cyc(av, 5'($urandom_range(0, 15)), $urandom,
                1'($urandom_range(0, 1)), 5'($urandom_range(0, 15)), $urandom,
                ($urandom_range(0, 3) == 0), 5'($urandom_range(0, 15)));
        end
    endtask

    task automatic reset_check(input string tag);
        chk({tag, "_we"}, 32'(wb_we), 0);
        chk({tag, "_addr"}, 32'(wb_addr), 0);
        chk({tag, "_data"}, wb_data, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_waw"}, 32'(waw_err), 0);
        chk({tag, "_rdy"}, 32'(lsu_rdy), 1);
        chk({tag, "_stall"}, 32'(stall), 0);
    endtask

    initial begin
        #1;
        reset_check("rst0");
        @(negedge clk);
        rst = 1'b1;
        // ALU write alone
        cyc(1, 5, 32'h12345678, 0, 0, 0, 0, 0);
        chk("alu_addr5", 32'(wb_addr), 5);
        chk("alu_data5", wb_data, 32'h12345678);
        // collision: ALU first, lsu next cycle
        cyc(1, 3, 32'hA, 1, 4, 32'hB, 0, 0);
        chk("coll_a", wb_data, 32'hA);
        idle();
        chk("coll_b", 32'(wb_addr), 4);
        // fill under continuous ALU, then drain in order
        cyc(1, 1, 32'h11, 1, 12, 32'hC1, 0, 0);
        chk("fill_stall", 32'(stall), 1);
        cyc(1, 2, 32'h22, 1, 13, 32'hC2, 0, 0);
        chk("fill_rdy", 32'(lsu_rdy), 0);
        cyc(1, 6, 32'h66, 1, 14, 32'hDEAD, 0, 0);
        idle();
        chk("drain1", wb_data, 32'hC1);
        idle();
        chk("drain2", wb_data, 32'hC2);
        idle();
        // scoreboard and sticky WAW
        cyc(0, 0, 0, 0, 0, 0, 1, 7);
        chk("busy7", 32'(busy[7]), 1);
        cyc(1, 7, 32'h77, 1, 7, 32'h700, 0, 0);
        chk("waw", 32'(waw_err), 1);
        idle();
        chk("busy7_clr", 32'(busy[7]), 0);
        // x0 entry popped without write; set wins over clear
        cyc(0, 0, 0, 1, 0, 32'hFF, 1, 9);
        cyc(1, 8, 32'h88, 1, 9, 32'h99, 0, 0);
        idle();
        chk("x0_pop", 32'(wb_we), 0);
        cyc(0, 0, 0, 0, 0, 0, 1, 9);
        chk("setwins", 32'(busy[9]), 1);
        rand_cycles(300);
        // reset with two buffered entries and busy=0x80
        rst = 1'b0;
        #1;
        @(negedge clk);
        rst = 1'b1;
        q.delete(); m_busy = '0; m_waw = 1'b0;
        cyc(0, 0, 0, 0, 0, 0, 1, 7);
        cyc(1, 1, 1, 1, 20, 32'h2020, 0, 0);
        cyc(1, 2, 2, 1, 21, 32'h2121, 0, 0);
        chk("pre_busy", busy, 32'h80);
        chk("pre_full", 32'(lsu_rdy), 0);
        #2;
        rst = 1'b0;
        #1;
        reset_check("rstmid");
        q.delete(); m_busy = '0; m_waw = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        idle();
        idle();
        rand_cycles(300);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
